// File: rtl/uartmodule_rx.sv
// 8N1 serial receiver on a 16x-oversampled baud enable; mid-bit sampling, framing-error and break recovery.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over the last three ticks for decision samples.
module uartmodule_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_50,
   input  logic       rst_n,
   input  logic       baud_x16,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [2:0]    bidx, bidx_nx;
   logic [7:0]    sh, sh_nx;
   logic [7:0]    data_nx;
   logic          valid_nx, ferr_nx;
   logic          sync1, rx_s;
   logic          samp;

`ifdef UART_RX_MAJORITY_EN
   // Two previous tick samples of rx_s; together with the current one they vote.
   logic [1:0] hist;

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         hist <= 2'b11;
      end else if (baud_x16) begin
         hist <= {hist[0], rx_s};
      end
   end

   assign samp = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
   assign samp = rx_s;
`endif

   assign rx_busy = (state != IDLE);

   always_ff @(posedge clk_50) begin
      if (!rst_n) begin
         sync1        <= 1'b1;
         rx_s         <= 1'b1;
         state        <= IDLE;
         tcnt         <= '0;
         bidx         <= '0;
         sh           <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         sync1        <= rx_serial;
         rx_s         <= sync1;
         state        <= state_nx;
         tcnt         <= tcnt_nx;
         bidx         <= bidx_nx;
         sh           <= sh_nx;
         rx_data      <= data_nx;
         rx_valid     <= valid_nx;
         rx_frame_err <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      tcnt_nx  = tcnt;
      bidx_nx  = bidx;
      sh_nx    = sh;
      data_nx  = rx_data;
      valid_nx = 1'b0;
      ferr_nx  = 1'b0;
      if (baud_x16) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_nx = START;
                  tcnt_nx  = '0;
               end
            end
            START: begin
               // Half a bit in: a line that has gone high again was only a glitch.
               if (tcnt == T_HALF) begin
                  tcnt_nx  = '0;
                  bidx_nx  = '0;
                  state_nx = samp ? IDLE : DATA;
               end else begin
                  tcnt_nx = tcnt + 1'b1;
               end
            end
            DATA: begin
               if (tcnt == T_FULL) begin
                  tcnt_nx       = '0;
                  sh_nx[bidx]   = samp;
                  if (bidx == 3'd7) begin
                     state_nx = STOP;
                  end else begin
                     bidx_nx = bidx + 3'd1;
                  end
               end else begin
                  tcnt_nx = tcnt + 1'b1;
               end
            end
            STOP: begin
               if (tcnt == T_FULL) begin
                  tcnt_nx = '0;
                  if (samp) begin
                     data_nx  = sh;
                     valid_nx = 1'b1;
                     state_nx = IDLE;
                  end else begin
                     ferr_nx  = 1'b1;
                     state_nx = BRK;
                  end
               end else begin
                  tcnt_nx = tcnt + 1'b1;
               end
            end
            BRK: begin
               // Stay here while the line is held low so a break reports only once.
               if (rx_s) begin
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uartmodule_rx.sv
// Bench for uartmodule_rx: table of frames plus hand-written glitch, break and reset sequences, scoreboard-checked.
module tb_uartmodule_rx;

   localparam int BAUD_DIV = 27;
   localparam int OS       = 16;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [7:0] G_DAT = 8'h96;
   localparam logic       G_ERR = 1'b0;
`else
   localparam logic [7:0] G_DAT = 8'h69;
   localparam logic       G_ERR = 1'b1;
`endif

   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic       baud_x16;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   uartmodule_rx #(.OVERSAMPLE(OS)) dut (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .baud_x16     (baud_x16),
      .rx_serial    (rx_serial),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy)
   );

   initial forever #10 clk_50 = ~clk_50;

   typedef struct {
      logic       err;
      logic [7:0] dat;
   } exp_t;

   typedef struct {
      logic [7:0] dat;
      logic       stp;
      logic [8:0] glitch;
      int         gap;
      logic       exp_err;
      logic [7:0] exp_dat;
   } vec_t;

   exp_t       sb[$];
   vec_t       tbl[7];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         bcnt = 0;
   int         busy_cnt = 0;
   logic       prev_strobe = 1'b0;
   logic [7:0] exp_last;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endfunction

   task automatic clk1();
      @(negedge clk_50);
      bcnt     = (bcnt == BAUD_DIV - 1) ? 0 : bcnt + 1;
      baud_x16 = (bcnt == 0);
   endtask

   // Returns on the negedge where the n-th following tick is asserted.
   task automatic tick_wait(input int n);
      repeat (n) begin
         clk1();
         while (!baud_x16) clk1();
      end
   endtask

   // One frame, tick-aligned; glitch[i] inverts the line for the single tick the receiver samples bit i.
   task automatic send_frame(input logic [7:0] d, input logic stp, input logic [8:0] g, input int gap,
                             input logic after, input logic e_err, input logic [7:0] e_dat);
      exp_t e;
      e.err = e_err;
      e.dat = e_dat;
      sb.push_back(e);
      if (!e_err) exp_last = e_dat;
      rx_serial = 1'b0;
      tick_wait(OS);
      for (int i = 0; i < 9; i++) begin
         logic b;
         b = (i < 8) ? d[i] : stp;
         rx_serial = b;
         tick_wait(OS / 2);
         if (g[i]) rx_serial = ~b;
         tick_wait(1);
         rx_serial = b;
         tick_wait(OS / 2 - 1);
      end
      rx_serial = after;
      tick_wait(gap);
   endtask

   always @(negedge clk_50) begin
      exp_t e;
      if (rx_valid || rx_frame_err) begin
         chk("strobe_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
         chk("strobe_width", 32'(prev_strobe), 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got valid=%0b err=%0b data=%0h, required no strobe",
                     rx_valid, rx_frame_err, rx_data);
         end else begin
            e = sb.pop_front();
            chk("strobe_kind_err", 32'(rx_frame_err), 32'(e.err));
            chk("strobe_rx_data", 32'(rx_data), 32'(e.dat));
         end
      end
      prev_strobe = rx_valid | rx_frame_err;
      if (rx_busy) busy_cnt++;
   end

   initial begin
      #(20 * 95000);
      $display("FAIL watchdog: run did not end, required finish within 95000 clocks");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      rx_serial = 1'b1;
      baud_x16  = 1'b0;
      exp_last  = 8'h00;

      tbl[0] = '{8'hA5, 1'b1, 9'h000, 32, 1'b0, 8'hA5};
      tbl[1] = '{8'h00, 1'b1, 9'h000,  0, 1'b0, 8'h00};
      tbl[2] = '{8'hFF, 1'b1, 9'h000,  0, 1'b0, 8'hFF};
      tbl[3] = '{8'h55, 1'b1, 9'h000, 32, 1'b0, 8'h55};
      tbl[4] = '{8'hC3, 1'b0, 9'h000, 32, 1'b1, 8'h55};
      tbl[5] = '{8'h96, 1'b1, 9'h0FF, 32, 1'b0, G_DAT};
      tbl[6] = '{8'h96, 1'b1, 9'h1FF, 32, G_ERR, G_DAT};

      repeat (3) clk1();
      chk("reset_rx_data", 32'(rx_data), 32'h00);
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
      chk("reset_rx_busy", 32'(rx_busy), 32'd0);
      rst_n = 1'b1;
      tick_wait(4);

      for (int k = 0; k < 7; k++)
         send_frame(tbl[k].dat, tbl[k].stp, tbl[k].glitch, tbl[k].gap, 1'b1, tbl[k].exp_err, tbl[k].exp_dat);
      tick_wait(8);
      chk("table_drain", 32'(sb.size()), 32'd0);
      chk("table_last_data", 32'(rx_data), 32'(exp_last));

      // Three-tick low glitch on an idle line.
      busy_cnt  = 0;
      rx_serial = 1'b0;
      tick_wait(3);
      rx_serial = 1'b1;
      tick_wait(20);
      chk("glitch_busy_clocks", 32'(busy_cnt), 32'(8 * BAUD_DIV));
      chk("glitch_busy_after", 32'(rx_busy), 32'd0);
      chk("glitch_drain", 32'(sb.size()), 32'd0);

      // Bad stop bit followed by a 20 bit-time break.
      send_frame(8'h3C, 1'b0, 9'h000, OS * 10, 1'b0, 1'b1, exp_last);
      chk("break_busy_mid", 32'(rx_busy), 32'd1);
      tick_wait(OS * 10);
      chk("break_busy_late", 32'(rx_busy), 32'd1);
      rx_serial = 1'b1;
      tick_wait(4);
      chk("break_busy_exit", 32'(rx_busy), 32'd0);
      chk("break_drain", 32'(sb.size()), 32'd0);
      chk("break_rx_data_held", 32'(rx_data), 32'(exp_last));
      tick_wait(16);

      // Reset in the middle of bit 4 of 0xF0, then a clean 0x81.
      rx_serial = 1'b0;
      tick_wait(OS);
      for (int i = 0; i < 4; i++) begin
         rx_serial = 1'b0;
         tick_wait(OS);
      end
      rx_serial = 1'b1;
      tick_wait(OS / 2);
      chk("mid_frame_busy", 32'(rx_busy), 32'd1);
      rst_n = 1'b0;
      clk1();
      rst_n = 1'b1;
      chk("rst_mid_rx_data", 32'(rx_data), 32'h00);
      chk("rst_mid_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_mid_rx_frame_err", 32'(rx_frame_err), 32'd0);
      chk("rst_mid_rx_busy", 32'(rx_busy), 32'd0);
      exp_last = 8'h00;
      tick_wait(OS / 2 + 4 * OS + 8);
      chk("rst_no_partial", 32'(rx_data), 32'h00);
      send_frame(8'h81, 1'b1, 9'h000, 32, 1'b1, 1'b0, 8'h81);
      tick_wait(8);
      chk("post_rst_drain", 32'(sb.size()), 32'd0);
      chk("post_rst_rx_data", 32'(rx_data), 32'h81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
